// File: rtl/iu_pkg.sv
// Shared types and helpers for the instruction-unit prediction checker.
package iu_pkg;

    localparam int unsigned PC_W_DEF = 64;

    typedef enum logic [1:0] {
        ST_CHECK   = 2'd0,
        ST_RECOVER = 2'd1,
        ST_ACK     = 2'd2
    } chk_state_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_val;
        max_val = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_val) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/iu_pc_fifo.sv
// In-order queue of predicted PCs; flush beats push, push into a full queue
// is accepted only when a pop frees a slot in the same cycle.
module iu_pc_fifo
    import iu_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [PC_W-1:0] push_data,
    input  logic            pop,
    input  logic            flush,
    output logic            full,
    output logic            empty,
    output logic [PC_W-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]     rd_ptr;
    logic [AW:0]     wr_ptr;
    logic [PC_W-1:0] mem [DEPTH];
    logic            do_push;
    logic            do_pop;

    // Extra MSB on the pointers separates full from empty.
    assign empty   = (rd_ptr == wr_ptr);
    assign full    = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/iu_pred_chk.sv
// Checks queued iu predictions against the retired PC stream, redirects iu on
// a mismatch and keeps saturating hit/miss statistics.
module iu_pred_chk
    import iu_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  pc_pre,
    input  logic             pc_pre_oe,
    input  logic             ret_valid,
    input  logic [PC_W-1:0]  ret_pc,
    output logic             ret_ready,
    output logic             miss,
    output logic [PC_W-1:0]  pc_curr,
    output logic             q_full,
    output logic             q_empty,
    output logic             ovf,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    chk_state_t      state;
    chk_state_t      state_nxt;
    logic [PC_W-1:0] q_head;
    logic            push_c;
    logic            hit_c;
    logic            mis_c;
    logic            ovf_set_c;

    iu_pc_fifo #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (pc_pre),
        .pop       (hit_c),
        .flush     (mis_c),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_CHECK;
        else        state <= state_nxt;
    end

    // RECOVER waits for the first stale prediction, ACK lets iu sample miss once.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CHECK:   if (mis_c)     state_nxt = ST_RECOVER;
            ST_RECOVER: if (pc_pre_oe) state_nxt = ST_ACK;
            ST_ACK:                    state_nxt = ST_CHECK;
            default:                   state_nxt = ST_CHECK;
        endcase
    end

    always_comb begin
        ret_ready = 1'b0;
        push_c    = 1'b0;
        hit_c     = 1'b0;
        mis_c     = 1'b0;
        ovf_set_c = 1'b0;
        if (state == ST_CHECK) begin
            ret_ready = !q_empty;
            push_c    = pc_pre_oe;
            hit_c     = ret_valid && !q_empty && (q_head == ret_pc);
            mis_c     = ret_valid && !q_empty && (q_head != ret_pc);
            ovf_set_c = pc_pre_oe && q_full && !hit_c && !mis_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss     <= 1'b0;
            pc_curr  <= '0;
            ovf      <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            miss <= (state_nxt != ST_CHECK);
            if (mis_c)     pc_curr  <= ret_pc;
            if (ovf_set_c) ovf      <= 1'b1;
            if (hit_c)     hit_cnt  <= CNT_W'(sat_inc(64'(hit_cnt), CNT_W));
            if (mis_c)     miss_cnt <= CNT_W'(sat_inc(64'(miss_cnt), CNT_W));
        end
    end

endmodule

// File: tb/tb_iu_pred_chk.sv
// Randomised and directed bench for iu_pred_chk against a queue-based model.
module tb_iu_pred_chk;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PC_W  = 64;
    localparam int unsigned CNT_W = 16;
    localparam int          CMAX  = 65535;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [PC_W-1:0]  pc_pre;
    logic             pc_pre_oe;
    logic             ret_valid;
    logic [PC_W-1:0]  ret_pc;
    logic             ret_ready;
    logic             miss;
    logic [PC_W-1:0]  pc_curr;
    logic             q_full;
    logic             q_empty;
    logic             ovf;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    iu_pred_chk #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_pre    (pc_pre),
        .pc_pre_oe (pc_pre_oe),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .ret_ready (ret_ready),
        .miss      (miss),
        .pc_curr   (pc_curr),
        .q_full    (q_full),
        .q_empty   (q_empty),
        .ovf       (ovf),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = checking, 1 = waiting for stale prediction, 2 = iu ack cycle.
    logic [PC_W-1:0] mq[$];
    int              m_phase;
    logic [PC_W-1:0] m_pc;
    logic            m_ovf;
    int              m_hits;
    int              m_misses;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase  = 0;
        m_pc     = '0;
        m_ovf    = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_step(input logic oe, input logic [PC_W-1:0] pre,
                              input logic rv, input logic [PC_W-1:0] rp);
        case (m_phase)
            0: begin
                if (rv && mq.size() != 0) begin
                    if (mq[0] == rp) begin
                        void'(mq.pop_front());
                        m_hits = (m_hits < CMAX) ? m_hits + 1 : CMAX;
                        if (oe) mq.push_back(pre);
                    end else begin
                        mq.delete();
                        m_misses = (m_misses < CMAX) ? m_misses + 1 : CMAX;
                        m_pc     = rp;
                        m_phase  = 1;
                    end
                end else if (oe) begin
                    if (mq.size() < DEPTH) mq.push_back(pre);
                    else                   m_ovf = 1'b1;
                end
            end
            1:       if (oe) m_phase = 2;
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        chk("ret_ready", 64'(ret_ready), 64'(m_phase == 0 && mq.size() != 0));
        chk("miss",      64'(miss),      64'(m_phase != 0));
        chk("pc_curr",   pc_curr,        m_pc);
        chk("q_full",    64'(q_full),    64'(mq.size() == DEPTH));
        chk("q_empty",   64'(q_empty),   64'(mq.size() == 0));
        chk("ovf",       64'(ovf),       64'(m_ovf));
        chk("hit_cnt",   64'(hit_cnt),   64'(m_hits));
        chk("miss_cnt",  64'(miss_cnt),  64'(m_misses));
    endtask

    // One clock: drive, compare at the falling edge, advance the model at the rising edge.
    task automatic cyc(input logic oe, input logic [PC_W-1:0] pre,
                       input logic rv, input logic [PC_W-1:0] rp);
        pc_pre_oe = oe;
        pc_pre    = pre;
        ret_valid = rv;
        ret_pc    = rp;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step(oe, pre, rv, rp);
        #1;
    endtask

    // Assert reset away from any edge and check that outputs clear immediately.
    task automatic async_reset(input string tag);
        pc_pre_oe = 1'b0;
        ret_valid = 1'b0;
        pc_pre    = '0;
        ret_pc    = '0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_miss"},      64'(miss),      64'd0);
        chk({tag, "_pc_curr"},   pc_curr,        64'd0);
        chk({tag, "_q_empty"},   64'(q_empty),   64'd1);
        chk({tag, "_q_full"},    64'(q_full),    64'd0);
        chk({tag, "_ovf"},       64'(ovf),       64'd0);
        chk({tag, "_hit_cnt"},   64'(hit_cnt),   64'd0);
        chk({tag, "_miss_cnt"},  64'(miss_cnt),  64'd0);
        chk({tag, "_ret_ready"}, 64'(ret_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [PC_W-1:0] rnd_pre;
        logic [PC_W-1:0] rnd_rp;
        logic            rnd_oe;
        logic            rnd_rv;

        rst_n     = 1'b0;
        pc_pre    = '0;
        pc_pre_oe = 1'b0;
        ret_valid = 1'b0;
        ret_pc    = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_q_empty", 64'(q_empty), 64'd1);
        chk("rst_miss",    64'(miss),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three matching predictions.
        cyc(1'b1, 64'h1004, 1'b0, 64'h0);
        cyc(1'b1, 64'h1008, 1'b0, 64'h0);
        cyc(1'b1, 64'h100C, 1'b0, 64'h0);
        cyc(1'b0, 64'h0, 1'b1, 64'h1004);
        cyc(1'b0, 64'h0, 1'b1, 64'h1008);
        cyc(1'b0, 64'h0, 1'b1, 64'h100C);
        chk("t1_hit_cnt",  64'(hit_cnt),  64'd3);
        chk("t1_miss_cnt", 64'(miss_cnt), 64'd0);
        chk("t1_q_empty",  64'(q_empty),  64'd1);
        chk("t1_miss",     64'(miss),     64'd0);

        // Hit then mismatch, recovery through ACK, then resume.
        async_reset("r1");
        cyc(1'b1, 64'h2004, 1'b0, 64'h0);
        cyc(1'b1, 64'h2008, 1'b0, 64'h0);
        cyc(1'b0, 64'h0, 1'b1, 64'h2004);
        chk("t2_miss_before", 64'(miss), 64'd0);
        cyc(1'b0, 64'h0, 1'b1, 64'h3000);
        chk("t2_miss",     64'(miss),     64'd1);
        chk("t2_pc_curr",  pc_curr,       64'h3000);
        chk("t2_q_empty",  64'(q_empty),  64'd1);
        chk("t2_hit_cnt",  64'(hit_cnt),  64'd1);
        chk("t2_miss_cnt", 64'(miss_cnt), 64'd1);
        cyc(1'b0, 64'h0, 1'b0, 64'h0);
        chk("t3_miss_hold", 64'(miss), 64'd1);
        cyc(1'b1, 64'h200C, 1'b0, 64'h0);
        chk("t3_miss_ack",  64'(miss),    64'd1);
        chk("t3_q_empty",   64'(q_empty), 64'd1);
        cyc(1'b0, 64'h0, 1'b0, 64'h0);
        chk("t3_miss_done", 64'(miss), 64'd0);
        cyc(1'b1, 64'h3004, 1'b0, 64'h0);
        chk("t3_queued", 64'(q_empty), 64'd0);
        cyc(1'b0, 64'h0, 1'b1, 64'h3004);
        chk("t3_hit_cnt", 64'(hit_cnt), 64'd2);

        // Overflow and push+pop while full.
        async_reset("r2");
        for (int i = 0; i <= DEPTH; i++) begin
            cyc(1'b1, 64'h4000 + 64'(4 * i), 1'b0, 64'h0);
            if (i == DEPTH - 1) begin
                chk("t4_full",    64'(q_full), 64'd1);
                chk("t4_ovf_pre", 64'(ovf),    64'd0);
            end
        end
        chk("t4_ovf", 64'(ovf), 64'd1);
        cyc(1'b1, 64'h5000, 1'b1, 64'h4000);
        chk("t4_full_pp", 64'(q_full),  64'd1);
        chk("t4_ovf_pp",  64'(ovf),     64'd1);
        chk("t4_hit_pp",  64'(hit_cnt), 64'd1);

        // Async reset with entries queued, then mid-RECOVER.
        async_reset("r3");
        for (int i = 0; i < 4; i++) cyc(1'b1, 64'h6000 + 64'(4 * i), 1'b0, 64'h0);
        cyc(1'b0, 64'h0, 1'b1, 64'h6000);
        chk("t5_nonempty", 64'(q_empty), 64'd0);
        async_reset("r4");
        for (int i = 0; i < 4; i++) cyc(1'b1, 64'h7000 + 64'(4 * i), 1'b0, 64'h0);
        cyc(1'b0, 64'h0, 1'b1, 64'hDEAD);
        chk("t5_in_recover", 64'(miss), 64'd1);
        async_reset("r5");

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rnd_oe  = ($urandom_range(0, 1) == 1);
            rnd_pre = {$urandom, $urandom};
            rnd_rv  = ($urandom_range(0, 2) != 0);
            if (mq.size() != 0 && $urandom_range(0, 7) != 0) rnd_rp = mq[0];
            else                                              rnd_rp = {$urandom, $urandom};
            cyc(rnd_oe, rnd_pre, rnd_rv, rnd_rp);
        end

        // Saturate the hit counter.
        async_reset("r6");
        cyc(1'b1, 64'h8000_0000, 1'b0, 64'h0);
        for (int i = 1; i <= CMAX; i++)
            cyc(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b1, 64'h8000_0000 + 64'(4 * (i - 1)));
        chk("t6_hit_max", 64'(hit_cnt), 64'hFFFF);
        cyc(1'b0, 64'h0, 1'b1, 64'h8000_0000 + 64'(4 * CMAX));
        chk("t6_hit_sat", 64'(hit_cnt),  64'hFFFF);
        chk("t6_empty",   64'(q_empty),  64'd1);
        chk("t6_miss",    64'(miss_cnt), 64'd0);
        cyc(1'b0, 64'h0, 1'b0, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
